// File: rtl/uart_pkg.sv
// Shared UART types and constants.
//   parity_mode_e : parity_mode_i encoding (0 none, 1 even, 2 odd, 3 none)
//   stop_bits_e   : stop_bits_i encoding (0 -> 1, 1 -> 1.5, 2 -> 2, 3 -> 1)
//   rx_state_e    : receiver FSM states
//   MIN_WORD_LEN  : smallest supported data-bit count
package uart_pkg;

    localparam int MIN_WORD_LEN = 5;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'd0,
        PAR_EVEN     = 2'd1,
        PAR_ODD      = 2'd2,
        PAR_NONE_ALT = 2'd3
    } parity_mode_e;

    typedef enum logic [1:0] {
        STOP_1     = 2'd0,
        STOP_1P5   = 2'd1,
        STOP_2     = 2'd2,
        STOP_1_ALT = 2'd3
    } stop_bits_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset; all flops load ResetVal
//   d_i   : asynchronous input
//   q_o   : synchronized output (Stages cycles of latency)
module uart_sync #(
    parameter int   Stages   = 2,
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_reg <= {Stages{ResetVal}};
        end else begin
            sync_reg <= {sync_reg[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_reg[Stages-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime frame format (5..MaxWordLength data bits,
// none/even/odd parity, 1/1.5/2 stop bits), 3-sample majority voting,
// false-start rejection and parity/framing/break detection.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   rx_i           : asynchronous serial line, idle high
//   sample_tick_i  : one-cycle enable at Oversample x baud
//   word_len_i, parity_mode_i, stop_bits_i : frame format, latched at start
//   rx_done_tick_o : one-cycle pulse when dout_o and the flags are updated
//   dout_o         : received word, right-justified
//   parity_err_o, frame_err_o, break_o : status of the last frame
//   busy_o         : receiver not idle
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int MaxWordLength = 9,
    parameter int Oversample    = 16,
    parameter int SyncStages    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rx_i,
    input  logic                     sample_tick_i,
    input  logic [3:0]               word_len_i,
    input  logic [1:0]               parity_mode_i,
    input  logic [1:0]               stop_bits_i,
    output logic                     rx_done_tick_o,
    output logic [MaxWordLength-1:0] dout_o,
    output logic                     parity_err_o,
    output logic                     frame_err_o,
    output logic                     break_o,
    output logic                     busy_o
);

    localparam int TcW  = $clog2(2 * Oversample);
    localparam int CntW = $clog2(MaxWordLength + 1);

    localparam logic [TcW-1:0] TcS0  = TcW'(Oversample / 2 - 1);
    localparam logic [TcW-1:0] TcS1  = TcW'(Oversample / 2);
    localparam logic [TcW-1:0] TcDec = TcW'(Oversample / 2 + 1);
    localparam logic [TcW-1:0] TcBit = TcW'(Oversample - 1);

    logic rxs;

    uart_sync #(
        .Stages   (SyncStages),
        .ResetVal (1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rxs)
    );

    rx_state_e              state_reg, state_next;
    logic [TcW-1:0]         tc_reg, tc_next;
    logic [CntW-1:0]        cnt_reg, cnt_next;
    logic [CntW-1:0]        wl_reg, wl_next;
    parity_mode_e           par_reg, par_next;
    stop_bits_e             stop_reg, stop_next;
    logic [MaxWordLength-1:0] sr_reg, sr_next;
    logic                   samp_a_reg, samp_a_next;
    logic                   samp_b_reg, samp_b_next;
    logic                   dpar_reg, dpar_next;   // running XOR of data bits
    logic                   zero_reg, zero_next;   // every bit so far was 0
    logic                   perr_reg, perr_next;
    logic                   ferr_reg, ferr_next;
    logic                   brk_reg, brk_next;
    logic                   done_reg, done_next;
    logic [MaxWordLength-1:0] dout_reg, dout_next;
    logic                   perr_out_reg, perr_out_next;
    logic                   ferr_out_reg, ferr_out_next;
    logic                   brk_out_reg, brk_out_next;

    // Position inside the current bit; in the 2-stop case tc runs across
    // both stop bits, so the second one is folded back onto 0..Oversample-1.
    logic           in_stop2;
    logic [TcW-1:0] pos;
    logic           maj;
    logic           dec_tick;
    logic           bit_end;
    logic           par_en;
    logic [TcW-1:0] stop_last;

    assign in_stop2 = (tc_reg >= TcW'(Oversample));
    assign pos      = in_stop2 ? (tc_reg - TcW'(Oversample)) : tc_reg;
    assign maj      = (samp_a_reg & samp_b_reg) | (samp_a_reg & rxs) | (samp_b_reg & rxs);
    assign dec_tick = sample_tick_i && (pos == TcDec);
    assign bit_end  = sample_tick_i && (tc_reg == TcBit);
    assign par_en   = (par_reg == PAR_EVEN) || (par_reg == PAR_ODD);

    always_comb begin
        case (stop_reg)
            STOP_1P5: stop_last = TcW'(3 * Oversample / 2 - 1);
            STOP_2:   stop_last = TcW'(2 * Oversample - 1);
            default:  stop_last = TcW'(Oversample - 1);
        endcase
    end

    // New bits enter at position wl-1 and everything below shifts right,
    // so after wl bits the word is right-justified with zero MSBs.
    logic [MaxWordLength-1:0] sr_shift;
    for (genvar gi = 0; gi < MaxWordLength; gi++) begin : g_shift
        if (gi == MaxWordLength - 1) begin : g_top
            assign sr_shift[gi] = (wl_reg == CntW'(gi + 1)) ? maj : 1'b0;
        end else begin : g_body
            assign sr_shift[gi] = (wl_reg == CntW'(gi + 1)) ? maj :
                                  (wl_reg >  CntW'(gi + 1)) ? sr_reg[gi + 1] : 1'b0;
        end
    end

    always_comb begin
        state_next    = state_reg;
        tc_next       = tc_reg;
        cnt_next      = cnt_reg;
        wl_next       = wl_reg;
        par_next      = par_reg;
        stop_next     = stop_reg;
        sr_next       = sr_reg;
        samp_a_next   = samp_a_reg;
        samp_b_next   = samp_b_reg;
        dpar_next     = dpar_reg;
        zero_next     = zero_reg;
        perr_next     = perr_reg;
        ferr_next     = ferr_reg;
        brk_next      = brk_reg;
        done_next     = 1'b0;
        dout_next     = dout_reg;
        perr_out_next = perr_out_reg;
        ferr_out_next = ferr_out_reg;
        brk_out_next  = brk_out_reg;

        if (state_reg != IDLE && sample_tick_i) begin
            tc_next = tc_reg + TcW'(1);
            if (pos == TcS0) samp_a_next = rxs;
            if (pos == TcS1) samp_b_next = rxs;
        end

        case (state_reg)
            IDLE: begin
                tc_next = '0;
                if (!rxs) begin
                    state_next = START;
                    if (word_len_i < 4'(MIN_WORD_LEN)) begin
                        wl_next = CntW'(MIN_WORD_LEN);
                    end else if (word_len_i > 4'(MaxWordLength)) begin
                        wl_next = CntW'(MaxWordLength);
                    end else begin
                        wl_next = CntW'(word_len_i);
                    end
                    par_next  = parity_mode_e'(parity_mode_i);
                    stop_next = stop_bits_e'(stop_bits_i);
                    sr_next   = '0;
                    cnt_next  = '0;
                    dpar_next = 1'b0;
                    zero_next = 1'b1;
                    perr_next = 1'b0;
                    ferr_next = 1'b0;
                    brk_next  = 1'b0;
                end
            end
            START: begin
                if (dec_tick && maj) begin
                    state_next = IDLE;   // glitch: silently drop back
                    tc_next    = '0;
                end else if (bit_end) begin
                    state_next = DATA;
                    tc_next    = '0;
                    cnt_next   = '0;
                end
            end
            DATA: begin
                if (dec_tick) begin
                    sr_next   = sr_shift;
                    dpar_next = dpar_reg ^ maj;
                    if (maj) zero_next = 1'b0;
                end
                if (bit_end) begin
                    tc_next = '0;
                    if (cnt_reg == wl_reg - CntW'(1)) begin
                        state_next = par_en ? PARITY : STOP;
                    end else begin
                        cnt_next = cnt_reg + CntW'(1);
                    end
                end
            end
            PARITY: begin
                if (dec_tick) begin
                    perr_next = dpar_reg ^ maj ^ (par_reg == PAR_ODD);
                    if (maj) zero_next = 1'b0;
                end
                if (bit_end) begin
                    state_next = STOP;
                    tc_next    = '0;
                end
            end
            STOP: begin
                if (dec_tick && (!in_stop2 || stop_reg == STOP_2)) begin
                    if (!maj) ferr_next = 1'b1;
                    if (!in_stop2) brk_next = zero_reg & ~maj;
                end
                if (sample_tick_i && tc_reg == stop_last) begin
                    done_next     = 1'b1;
                    dout_next     = brk_reg ? '0 : sr_reg;
                    perr_out_next = perr_reg;
                    ferr_out_next = ferr_reg;
                    brk_out_next  = brk_reg;
                    state_next    = brk_reg ? BRK_WAIT : IDLE;
                    tc_next       = '0;
                end
            end
            BRK_WAIT: begin
                tc_next = '0;
                if (rxs) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                tc_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            tc_reg       <= '0;
            cnt_reg      <= '0;
            wl_reg       <= '0;
            par_reg      <= PAR_NONE;
            stop_reg     <= STOP_1;
            sr_reg       <= '0;
            samp_a_reg   <= 1'b0;
            samp_b_reg   <= 1'b0;
            dpar_reg     <= 1'b0;
            zero_reg     <= 1'b0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            brk_reg      <= 1'b0;
            done_reg     <= 1'b0;
            dout_reg     <= '0;
            perr_out_reg <= 1'b0;
            ferr_out_reg <= 1'b0;
            brk_out_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tc_reg       <= tc_next;
            cnt_reg      <= cnt_next;
            wl_reg       <= wl_next;
            par_reg      <= par_next;
            stop_reg     <= stop_next;
            sr_reg       <= sr_next;
            samp_a_reg   <= samp_a_next;
            samp_b_reg   <= samp_b_next;
            dpar_reg     <= dpar_next;
            zero_reg     <= zero_next;
            perr_reg     <= perr_next;
            ferr_reg     <= ferr_next;
            brk_reg      <= brk_next;
            done_reg     <= done_next;
            dout_reg     <= dout_next;
            perr_out_reg <= perr_out_next;
            ferr_out_reg <= ferr_out_next;
            brk_out_reg  <= brk_out_next;
        end
    end

    assign rx_done_tick_o = done_reg;
    assign dout_o         = dout_reg;
    assign parity_err_o   = perr_out_reg;
    assign frame_err_o    = ferr_out_reg;
    assign break_o        = brk_out_reg;
    assign busy_o         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx_i = 1'b1;
    logic       sample_tick_i = 1'b0;
    logic [3:0] word_len_i = 4'd8;
    logic [1:0] parity_mode_i = 2'd0;
    logic [1:0] stop_bits_i = 2'd0;
    logic       rx_done_tick_o;
    logic [8:0] dout_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       break_o;
    logic       busy_o;

    uart_rx_cfg #(
        .MaxWordLength (9),
        .Oversample    (16),
        .SyncStages    (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rx_i           (rx_i),
        .sample_tick_i  (sample_tick_i),
        .word_len_i     (word_len_i),
        .parity_mode_i  (parity_mode_i),
        .stop_bits_i    (stop_bits_i),
        .rx_done_tick_o (rx_done_tick_o),
        .dout_o         (dout_o),
        .parity_err_o   (parity_err_o),
        .frame_err_o    (frame_err_o),
        .break_o        (break_o),
        .busy_o         (busy_o)
    );

    typedef struct {
        logic [8:0] dout;
        logic       perr;
        logic       ferr;
        logic       brk;
        int         start;
        int         len;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_pass = 0;
    int         tick_cnt = 0;
    logic [1:0] div = 2'd0;

    always #5 clk_i = ~clk_i;

    // One sample tick every 4 clocks; tick_cnt counts ticks consumed so far.
    always @(posedge clk_i) begin
        #1;
        if (sample_tick_i) tick_cnt++;
        div = div + 2'd1;
        sample_tick_i = (div == 2'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            while (!sample_tick_i) @(posedge clk_i);
        end
    endtask

    task automatic seg(input logic v, input int n);
        #2;
        rx_i = v;
        wait_ticks(n);
    endtask

    // bad_stop: 0 good, 1 stop bit 1 low, 2 stop bit 2 low (2-stop frames)
    task automatic send_frame(input logic [8:0] data, input logic [3:0] wl_in,
                              input logic [1:0] pm, input logic [1:0] sb,
                              input bit flip, input int glitch_bit, input int bad_stop);
        int         wl;
        int         stop_ticks;
        int         has_par;
        logic       p;
        logic [8:0] d;
        exp_t       e;
        wl = (wl_in < 4'd5) ? 5 : (wl_in > 4'd9) ? 9 : int'(wl_in);
        d = data & ((9'h1 << wl) - 9'h1);
        stop_ticks = (sb == 2'd1) ? 24 : (sb == 2'd2) ? 32 : 16;
        has_par = (pm == 2'd1 || pm == 2'd2) ? 1 : 0;
        p = ^d;
        if (pm == 2'd2) p = ~p;
        if (flip) p = ~p;
        #2;
        word_len_i = wl_in;
        parity_mode_i = pm;
        stop_bits_i = sb;
        e.dout = d;
        e.perr = flip && (has_par == 1);
        e.ferr = (bad_stop != 0);
        e.brk = 1'b0;
        e.start = tick_cnt;
        e.len = 16 * (1 + wl + has_par) + stop_ticks;
        exp_q.push_back(e);
        rx_i = 1'b0;
        wait_ticks(16);
        // Mid-frame config changes must have no effect.
        word_len_i = 4'($urandom_range(0, 15));
        parity_mode_i = 2'($urandom_range(0, 3));
        stop_bits_i = 2'($urandom_range(0, 3));
        for (int i = 0; i < wl; i++) begin
            if (i == glitch_bit) begin
                seg(d[i], 7);
                seg(1'b0, 1);
                seg(d[i], 8);
            end else begin
                seg(d[i], 16);
            end
        end
        if (has_par == 1) seg(p, 16);
        if (bad_stop == 1) begin
            seg(1'b0, 16);
            if (stop_ticks > 16) seg(1'b1, stop_ticks - 16);
        end else if (bad_stop == 2) begin
            seg(1'b1, 16);
            seg(1'b0, 16);
        end else begin
            seg(1'b1, stop_ticks);
        end
    endtask

    always @(negedge clk_i) begin
        if (rx_done_tick_o) begin
            check("done_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                int diff;
                int lat_got;
                mon_e = exp_q.pop_front();
                diff = tick_cnt - mon_e.start;
                lat_got = (diff >= mon_e.len - 2 && diff <= mon_e.len + 2) ? mon_e.len : diff;
                $display("frame: dout=0x%03h perr=%0d ferr=%0d brk=%0d ticks=%0d",
                         dout_o, parity_err_o, frame_err_o, break_o, diff);
                check("dout", dout_o, mon_e.dout);
                check("parity_err", parity_err_o, mon_e.perr);
                check("frame_err", frame_err_o, mon_e.ferr);
                check("break", break_o, mon_e.brk);
                check("latency", lat_got, mon_e.len);
            end
        end
    end

    initial begin
        exp_t e;
        repeat (4) @(negedge clk_i);
        check("rst_done", rx_done_tick_o, 0);
        check("rst_dout", dout_o, 0);
        check("rst_perr", parity_err_o, 0);
        check("rst_ferr", frame_err_o, 0);
        check("rst_brk", break_o, 0);
        check("rst_busy", busy_o, 0);
        rst_i = 1'b0;
        seg(1'b1, 20);

        // 8N1, then 7E2 good/bad parity
        send_frame(9'h0A5, 4'd8, 2'd0, 2'd0, 1'b0, -1, 0);
        seg(1'b1, 10);
        send_frame(9'h041, 4'd7, 2'd1, 2'd2, 1'b0, -1, 0);
        seg(1'b1, 10);
        send_frame(9'h041, 4'd7, 2'd1, 2'd2, 1'b1, -1, 0);
        seg(1'b1, 10);

        // 9O1 then 5N1.5 back-to-back
        send_frame(9'h1FF, 4'd9, 2'd2, 2'd0, 1'b0, -1, 0);
        send_frame(9'h015, 4'd5, 2'd0, 2'd1, 1'b0, -1, 0);
        seg(1'b1, 20);

        // False start: 4 ticks low
        seg(1'b0, 4);
        seg(1'b1, 3);
        #2;
        check("glitch_busy_hi", busy_o, 1);
        seg(1'b1, 12);
        #2;
        check("glitch_busy_lo", busy_o, 0);
        check("hold_dout", dout_o, 9'h015);
        check("hold_perr", parity_err_o, 0);
        check("hold_ferr", frame_err_o, 0);

        // Single-tick dropout inside data bit 2 at tc=7
        send_frame(9'h0FF, 4'd8, 2'd0, 2'd0, 1'b0, 2, 0);
        seg(1'b1, 10);

        // Word-length clamping both ends
        send_frame(9'h1F3, 4'd3, 2'd0, 2'd0, 1'b0, -1, 0);
        seg(1'b1, 10);
        send_frame(9'h1A6, 4'd15, 2'd1, 2'd0, 1'b0, -1, 0);
        seg(1'b1, 10);

        // Framing errors in stop bit 1 and stop bit 2
        send_frame(9'h05A, 4'd8, 2'd0, 2'd2, 1'b0, -1, 1);
        seg(1'b1, 10);
        send_frame(9'h033, 4'd6, 2'd0, 2'd2, 1'b0, -1, 2);
        seg(1'b1, 20);

        // Break: 30 bit times low in 8N1
        #2;
        word_len_i = 4'd8;
        parity_mode_i = 2'd0;
        stop_bits_i = 2'd0;
        e.dout = 9'h000;
        e.perr = 1'b0;
        e.ferr = 1'b1;
        e.brk = 1'b1;
        e.start = tick_cnt;
        e.len = 160;
        exp_q.push_back(e);
        rx_i = 1'b0;
        wait_ticks(300);
        #2;
        check("brk_busy_hi", busy_o, 1);
        wait_ticks(180);
        seg(1'b1, 2);
        #2;
        check("brk_busy_lo", busy_o, 0);
        seg(1'b1, 10);

        // Reset during data bit 3
        seg(1'b0, 16);
        seg(1'b1, 16);
        seg(1'b0, 16);
        seg(1'b1, 16);
        seg(1'b1, 5);
        #2;
        check("mid_busy", busy_o, 1);
        #3;
        rst_i = 1'b1;
        #1;
        check("mrst_done", rx_done_tick_o, 0);
        check("mrst_dout", dout_o, 0);
        check("mrst_perr", parity_err_o, 0);
        check("mrst_ferr", frame_err_o, 0);
        check("mrst_brk", break_o, 0);
        check("mrst_busy", busy_o, 0);
        rx_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        seg(1'b1, 20);
        send_frame(9'h03C, 4'd8, 2'd0, 2'd0, 1'b0, -1, 0);
        seg(1'b1, 10);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk_i);
        check("queue_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
